// File: rtl/crossbar_cfg_loader.sv
// Shadow/active selector bank for the PMU event crossbar. A commit copies the
// shadow bank to the active bank and then holds the counters cleared.
module crossbar_cfg_loader #(
  parameter  int N_OUT       = 24,
  parameter  int N_IN        = 32,
  parameter  int REG_WIDTH   = 32,
  parameter  int HOLD_CYCLES = 2,
  localparam int SEL_W       = $clog2(N_IN),
  localparam int FPR         = REG_WIDTH / SEL_W,
  localparam int N_WORDS     = (N_OUT + FPR - 1) / FPR,
  localparam int AW          = $clog2(N_WORDS + 1)
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   wr_valid_i,
  output logic                   wr_ready_o,
  input  logic [AW-1:0]          wr_addr_i,
  input  logic [REG_WIDTH-1:0]   wr_data_i,
  input  logic [AW-1:0]          rd_addr_i,
  output logic [REG_WIDTH-1:0]   rd_data_o,
  output logic [N_OUT*SEL_W-1:0] cfg_o,
  output logic                   cnt_clear_o,
  output logic                   commit_done_o,
  output logic                   err_o
);

  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int NSYM = 1 << SEL_W;
  // Bit v set when selector value v names an existing event.
  localparam logic [NSYM-1:0] LEGAL_MASK = {NSYM{1'b1}} >> (NSYM - N_IN);

  function automatic logic [N_OUT*SEL_W-1:0] identity_map();
    logic [N_OUT*SEL_W-1:0] v;
    v = {(N_OUT*SEL_W){1'b0}};
    for (int i = 0; i < N_OUT; i++) begin
      v[i*SEL_W +: SEL_W] = SEL_W'(i);
    end
    return v;
  endfunction

  localparam logic [N_OUT*SEL_W-1:0] IDENTITY = identity_map();

  typedef enum logic [1:0] {IDLE = 2'd0, COPY = 2'd1, HOLD = 2'd2} state_e;

  state_e                 state_r;
  logic [HC_W-1:0]        hold_cnt_r;
  logic [N_OUT*SEL_W-1:0] shadow_r;
  logic [N_OUT*SEL_W-1:0] active_r;
  logic                   dirty_r;
  logic                   err_r;
  logic                   wr_ready_r;
  logic                   cnt_clear_r;
  logic                   commit_done_r;
  logic [REG_WIDTH-1:0]   rd_data_r;

  logic                   wr_fire_s;
  logic                   ctrl_hit_s;
  logic                   word_hit_s;
  logic                   bad_s;
  logic [N_OUT*SEL_W-1:0] shadow_nxt_s;
  logic [REG_WIDTH-1:0]   rd_nxt_s;
  logic                   unused_ok_s;

  assign unused_ok_s = ^wr_data_i;

  // Write decode: candidate shadow image and selector legality for the addressed word.
  always_comb begin
    wr_fire_s    = wr_valid_i & wr_ready_r;
    ctrl_hit_s   = (wr_addr_i == AW'(N_WORDS));
    word_hit_s   = (wr_addr_i < AW'(N_WORDS));
    shadow_nxt_s = shadow_r;
    bad_s        = 1'b0;
    for (int i = 0; i < N_OUT; i++) begin
      if (wr_addr_i == AW'(i / FPR)) begin
        shadow_nxt_s[i*SEL_W +: SEL_W] = wr_data_i[(i % FPR)*SEL_W +: SEL_W];
        bad_s = bad_s | ~LEGAL_MASK[wr_data_i[(i % FPR)*SEL_W +: SEL_W]];
      end else begin
        bad_s = bad_s;
      end
    end
  end

  // Read mux: shadow words, CTRL status, zero elsewhere.
  always_comb begin
    rd_nxt_s = {REG_WIDTH{1'b0}};
    for (int i = 0; i < N_OUT; i++) begin
      if (rd_addr_i == AW'(i / FPR)) begin
        rd_nxt_s[(i % FPR)*SEL_W +: SEL_W] = shadow_r[i*SEL_W +: SEL_W];
      end else begin
        rd_nxt_s = rd_nxt_s;
      end
    end
    if (rd_addr_i == AW'(N_WORDS)) begin
      rd_nxt_s[2:0] = {dirty_r, err_r, (state_r != IDLE)};
    end else begin
      rd_nxt_s = rd_nxt_s;
    end
  end

  // Commit FSM together with the shadow/active banks and all registered outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r       <= IDLE;
      hold_cnt_r    <= {HC_W{1'b0}};
      shadow_r      <= IDENTITY;
      active_r      <= IDENTITY;
      dirty_r       <= 1'b0;
      err_r         <= 1'b0;
      wr_ready_r    <= 1'b1;
      cnt_clear_r   <= 1'b0;
      commit_done_r <= 1'b0;
      rd_data_r     <= {REG_WIDTH{1'b0}};
    end else begin
      rd_data_r <= rd_nxt_s;
      case (state_r)
        IDLE: begin
          commit_done_r <= 1'b0;
          if (wr_fire_s && word_hit_s) begin
            if (bad_s) begin
              err_r <= 1'b1;
            end else begin
              shadow_r <= shadow_nxt_s;
              dirty_r  <= 1'b1;
            end
          end else if (wr_fire_s && ctrl_hit_s) begin
            if (wr_data_i[1]) begin
              err_r <= 1'b0;
            end
            if (wr_data_i[0]) begin
              state_r     <= COPY;
              wr_ready_r  <= 1'b0;
              cnt_clear_r <= 1'b1;
            end
          end
        end
        COPY: begin
          active_r   <= shadow_r;
          dirty_r    <= 1'b0;
          hold_cnt_r <= HC_W'(HOLD_CYCLES - 1);
          state_r    <= HOLD;
        end
        HOLD: begin
          if (hold_cnt_r == {HC_W{1'b0}}) begin
            state_r       <= IDLE;
            cnt_clear_r   <= 1'b0;
            wr_ready_r    <= 1'b1;
            commit_done_r <= 1'b1;
          end else begin
            hold_cnt_r <= hold_cnt_r - HC_W'(1);
          end
        end
        default: begin
          state_r     <= IDLE;
          cnt_clear_r <= 1'b0;
          wr_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign wr_ready_o    = wr_ready_r;
  assign rd_data_o     = rd_data_r;
  assign cfg_o         = active_r;
  assign cnt_clear_o   = cnt_clear_r;
  assign commit_done_o = commit_done_r;
  assign err_o         = err_r;

endmodule

// File: doc/crossbar_cfg_loader.md
Name: crossbar_cfg_loader

Overview:
- Register-mapped configuration writer that drives the selector inputs of the PMU event crossbar, one selector per counter.
- Software writes packed selector words into a shadow bank. A commit copies shadow to active atomically, then holds a counter-clear window so no counter accumulates events across a mapping change.
- Sits between the PMU register interface and the crossbar's cfg input.

Parameters:
- N_OUT, 24, number of selectors (PMU counters).
- N_IN, 32, number of SoC events; N_IN >= N_OUT required.
- REG_WIDTH, 32, register word width.
- HOLD_CYCLES, 2, clear-window cycles after the active update; must be >= 1.
- Derived (local):
  - SEL_W = $clog2(N_IN)
  - FPR = REG_WIDTH/SEL_W
  - N_WORDS = ceil(N_OUT/FPR)
  - AW = $clog2(N_WORDS+1)

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  asynchronous active-low reset.
- wr_valid_i  in  1  write request.
- wr_ready_o  out  1  write accepted when valid&ready at a rising edge.
- wr_addr_i  in  AW  word address.
- wr_data_i  in  REG_WIDTH  write data.
- rd_addr_i  in  AW  read word address.
- rd_data_o  out  REG_WIDTH  registered read data.
- cfg_o  out  N_OUT*SEL_W  active selectors, flattened; selector i at [i*SEL_W +: SEL_W].
- cnt_clear_o  out  1  counter clear/hold request.
- commit_done_o  out  1  one-cycle pulse at end of commit.
- err_o  out  1  sticky invalid-selector flag.

Behaviour:
- Reset:
  - Reset is clk_i/rstn_i: asynchronous, active-low.
  - Shadow and active selector i = i (identity mapping).
  - State IDLE; dirty = 0; err_o = 0; cnt_clear_o = 0; commit_done_o = 0; rd_data_o = 0; wr_ready_o = 1 after reset.
- Address map:
  - Words 0..N_WORDS-1: shadow selectors. Field k (bits [k*SEL_W +: SEL_W]) of word w is selector w*FPR+k.
  - Fields with index >= N_OUT and bits above FPR*SEL_W are ignored on write and read as 0.
  - Word N_WORDS is CTRL:
    - Write bit0 = commit; write bit1 = clear err.
    - Read bit0 = busy (state != IDLE), bit1 = err, bit2 = dirty.
  - Other addresses: writes accepted and ignored; reads return 0.
- Shadow write (accepted, IDLE only):
  - If any in-range field value is >= N_IN, the whole write is rejected: shadow unchanged, err set.
  - Otherwise the shadow word is updated and dirty is set.
- Read: rd_addr_i is sampled every edge; rd_data_o is valid the following cycle. Reads always return shadow, never active.
- wr_ready_o = 1 only in IDLE. Writes are never accepted in COPY or HOLD; the master stalls.
- FSM:
  - IDLE → COPY on accepted CTRL write with bit0 = 1. Commit proceeds even when dirty = 0.
  - COPY (1 cycle): cnt_clear_o = 1. At the closing edge: active <= shadow (all selectors simultaneously), dirty <= 0, state → HOLD, hold_cnt <= HOLD_CYCLES-1.
  - HOLD: cnt_clear_o = 1. hold_cnt decrements each edge; at 0 → IDLE.
  - On the first IDLE cycle after HOLD: commit_done_o = 1 for exactly one cycle.
- Timing: cnt_clear_o is high for exactly 1+HOLD_CYCLES consecutive cycles. cfg_o changes only at the COPY→HOLD edge.
- Simultaneous CTRL bits:
  - bit0|bit1 in the same write: err cleared and commit started.
  - Commit is not blocked by err.
  - A rejected write and an err clear never coincide, since there is a single write port.
- Reset mid-commit (any state): immediate return to reset values.
  - Active reverts to identity.
  - cnt_clear_o and commit_done_o drop asynchronously.
  - The pending commit is lost.

Test Plan:
- Reset, N_IN = 32 → cfg_o selector 5 = 5, selector 23 = 23; read word0 → 0x0A418820 one cycle after rd_addr_i = 0; read CTRL → 0x0.
- Write word0 = 0x0000001F → read word0 = 0x0000001F, CTRL = 0x4 (dirty), cfg_o selector0 still 0. Then commit (CTRL = 0x1) → wr_ready_o low 3 cycles; cnt_clear_o high 3 cycles; selector0 = 31 from the edge after COPY; commit_done_o pulses once; CTRL reads 0x0.
- N_IN = 20 build: write word1 with field0 = 25 → shadow word1 unchanged, err_o = 1, CTRL = 0x2. Write CTRL = 0x2 → err_o = 0.
- Issue writes back-to-back during a commit (HOLD_CYCLES = 4) → each write stalls until IDLE; no shadow change before commit_done_o; first stalled write lands in the cycle after the commit_done_o cycle.
- Assert rstn_i low during HOLD after word0 = 0x1F was committed → cfg_o selector0 = 0 immediately, cnt_clear_o = 0, no commit_done_o after release.
- Write address 7 and word3 upper bits 31:30 = 2'b11 → no state change except word3 fields; read of bits 31:30 returns 0; read of address 7 returns 0.
